// File: rtl/cva6_rvfi_trace_fifo.sv
// RVFI trace FIFO: compacts per-port retirements into an order-tagged single-issue stream.
// Optional commit throttle output enabled by defining CVA6_RVFI_TRACE_STALL_EN.

package cva6_rvfi_trace_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] insn;
        logic        trap;
    } rvfi_instr_t;

endpackage

module cva6_rvfi_trace_fifo #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned Depth         = 8,
    parameter type         rvfi_instr_t  = cva6_rvfi_trace_pkg::rvfi_instr_t,
    parameter int unsigned CntW          = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  rvfi_instr_t [NrCommitPorts-1:0]      rvfi_i,
    input  logic                                 clear_i,
    output logic                                 trace_valid_o,
    input  logic                                 trace_ready_i,
    output rvfi_instr_t                          trace_o,
    output logic [63:0]                          trace_order_o,
    output logic [$clog2(Depth+1)-1:0]           count_o,
    output logic                                 overflow_o,
    output logic [CntW-1:0]                      drop_cnt_o,
    output logic                                 stall_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CountW = $clog2(Depth + 1);
    localparam int unsigned NvW    = $clog2(NrCommitPorts + 1);

    rvfi_instr_t       r_mem     [Depth];
    logic [63:0]       r_ord_mem [Depth];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CountW-1:0] r_count;
    logic [63:0]       r_order;
    logic [CntW-1:0]   r_drop;
    logic              r_ovf;

    logic [PtrW-1:0]   w_off   [NrCommitPorts];
    logic [PtrW-1:0]   w_waddr [NrCommitPorts];
    logic [NvW-1:0]    w_nvalid;
    logic              w_pop;
    logic [CountW-1:0] w_free;
    logic              w_fits;
    logic              w_push;
    logic [CountW-1:0] w_count_next;
    logic [CntW:0]     w_drop_sum;
    logic [CntW-1:0]   w_drop_next;

    // Each valid port lands at wr_ptr plus the number of valid ports below it.
    always_comb begin
        w_nvalid = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            w_off[i]   = PtrW'(w_nvalid);
            w_waddr[i] = r_wr_ptr + PtrW'(w_nvalid);
            w_nvalid   = w_nvalid + NvW'(rvfi_i[i].valid);
        end
    end

    always_comb begin
        w_pop        = (r_count != '0) && trace_ready_i;
        w_free       = CountW'(Depth) - r_count + CountW'(w_pop);
        w_fits       = CountW'(w_nvalid) <= w_free;
        w_push       = !rst_i && !clear_i && w_fits && (w_nvalid != '0);
        w_count_next = r_count + (w_fits ? CountW'(w_nvalid) : CountW'(0)) - CountW'(w_pop);
        w_drop_sum   = {1'b0, r_drop} + (CntW + 1)'(w_nvalid);
        w_drop_next  = w_drop_sum[CntW] ? '1 : w_drop_sum[CntW-1:0];
    end

    // Storage is not reset; the output mux hides stale contents while empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            for (int i = 0; i < NrCommitPorts; i++) begin
                if (rvfi_i[i].valid) begin
                    r_mem[w_waddr[i]]     <= rvfi_i[i];
                    r_ord_mem[w_waddr[i]] <= r_order + 64'(w_off[i]);
                end
            end
        end
    end

    // Order counter advances on every retirement, so drops and clears leave visible gaps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_order  <= '0;
            r_drop   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_order <= r_order + 64'(w_nvalid);
            if (clear_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_drop   <= '0;
                r_ovf    <= 1'b0;
            end else begin
                r_count <= w_count_next;
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PtrW'(1);
                end
                if (w_fits) begin
                    r_wr_ptr <= r_wr_ptr + PtrW'(w_nvalid);
                end else begin
                    r_drop <= w_drop_next;
                    r_ovf  <= 1'b1;
                end
            end
        end
    end

`ifdef CVA6_RVFI_TRACE_STALL_EN
    logic r_stall;

    // Headroom of two full commit bundles covers the core's one-cycle reaction time.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= w_count_next > CountW'(Depth - 2 * NrCommitPorts);
        end
    end

    assign stall_o = r_stall;
`else
    assign stall_o = 1'b0;
`endif

    assign trace_valid_o = (r_count != '0);
    assign trace_o       = trace_valid_o ? r_mem[r_rd_ptr] : '0;
    assign trace_order_o = trace_valid_o ? r_ord_mem[r_rd_ptr] : 64'd0;
    assign count_o       = r_count;
    assign overflow_o    = r_ovf;
    assign drop_cnt_o    = r_drop;

endmodule
